// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-over-SPI responder: FSM states,
// command indices, tokens and the R1 status encoder.
package sd_spi_pkg;

  typedef enum logic [3:0] {
    IDLE, CMD_RX, NCR, R1, RD_GAP, RD_TOKEN, RD_DATA, RD_CRC,
    WR_WAIT, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
  } state_t;

  localparam logic [5:0] CMD_GO_IDLE      = 6'd0;
  localparam logic [5:0] CMD_SET_BLOCKLEN = 6'd16;
  localparam logic [5:0] CMD_READ_SINGLE  = 6'd17;
  localparam logic [5:0] CMD_WRITE_SINGLE = 6'd24;
  localparam logic [5:0] CMD_SD_SEND_OP   = 6'd41;
  localparam logic [5:0] CMD_APP          = 6'd55;

  localparam logic [7:0] TOKEN_START       = 8'hFE;
  localparam logic [7:0] TOKEN_DATA_ACCEPT = 8'h05;
  localparam logic [7:0] BYTE_IDLE         = 8'hFF;
  localparam logic [7:0] R1_IN_IDLE        = 8'h01;
  localparam logic [7:0] R1_ILLEGAL        = 8'h04;

  localparam int unsigned BLOCK_BYTES = 512;
  localparam logic [8:0]  ADDR_LAST   = 9'(BLOCK_BYTES - 1);

  // app is the "previous command was CMD55" flag, idle the current in_idle bit.
  function automatic logic [7:0] r1_for(input logic [5:0] idx, input logic app,
                                        input logic idle);
    logic [7:0] status;
    logic [7:0] result;
    status = {7'd0, idle};
    case (idx)
      CMD_GO_IDLE:                       result = R1_IN_IDLE;
      CMD_APP, CMD_SET_BLOCKLEN:         result = status;
      CMD_SD_SEND_OP:                    result = app ? 8'h00 : (R1_ILLEGAL | status);
      CMD_READ_SINGLE, CMD_WRITE_SINGLE: result = idle ? (R1_ILLEGAL | R1_IN_IDLE) : 8'h00;
      default:                           result = R1_ILLEGAL | status;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/spi_slave_byte.sv
// Mode-0 SPI byte engine: synchronizes cs/sclk/mosi into clk, frames bytes,
// pulses rx_valid per received byte and tx_load when tx_byte is taken.
module spi_slave_byte
  import sd_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       active,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic [7:0] tx_byte,
  output logic       tx_load
);

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic       sclk_prev;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [6:0] tx_shift;
  logic       sclk_s, mosi_s, rise, fall;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign active = ~cs_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev;
  assign fall   = ~sclk_s & sclk_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      tx_shift  <= BYTE_IDLE[6:0];
      tx_load   <= 1'b0;
      miso      <= 1'b1;
    end else begin
      cs_sync   <= SYNC_STAGES'({cs_sync, cs});
      sclk_sync <= SYNC_STAGES'({sclk_sync, sclk});
      mosi_sync <= SYNC_STAGES'({mosi_sync, mosi});
      sclk_prev <= sclk_s;
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      if (!active) begin
        bit_cnt  <= '0;
        miso     <= 1'b1;
        tx_shift <= BYTE_IDLE[6:0];
      end else begin
        if (rise) begin
          rx_shift <= {rx_shift[5:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_byte  <= {rx_shift, mosi_s};
            rx_valid <= 1'b1;
          end
        end
        // The falling edge that closes a byte puts the next byte's MSB on miso.
        if (fall) begin
          if (bit_cnt == 3'd0) begin
            miso     <= tx_byte[7];
            tx_shift <= tx_byte[6:0];
            tx_load  <= 1'b1;
          end else begin
            miso     <= tx_shift[6];
            tx_shift <= {tx_shift[5:0], 1'b1};
          end
        end
      end
    end
  end

endmodule

// File: rtl/sd_spi_responder.sv
// SD-card SPI-mode responder: decodes 6-byte commands, answers R1 and runs
// single-block read (CMD17) and write (CMD24) transfers against a byte memory.
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int unsigned BUSY_BYTES  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic [31:0] blk_addr,
  output logic [8:0]  mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index
);

  localparam logic [8:0] BUSY_LAST = 9'(BUSY_BYTES - 1);

  logic        active, rx_valid, tx_load;
  logic [7:0]  rx_byte, tx_byte;
  state_t      state;
  logic [8:0]  cnt;
  logic [5:0]  cur_index;
  logic [31:0] arg;
  logic [7:0]  r1_resp;
  logic        in_idle, app_cmd, rd_go, wr_go;

  spi_slave_byte #(.SYNC_STAGES(SYNC_STAGES)) u_byte (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .active   (active),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .tx_byte  (tx_byte),
    .tx_load  (tx_load)
  );

  // Every decision is taken at rx_valid and chooses the byte for the next slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_index <= '0;
      arg       <= '0;
      r1_resp   <= BYTE_IDLE;
      in_idle   <= 1'b1;
      app_cmd   <= 1'b0;
      rd_go     <= 1'b0;
      wr_go     <= 1'b0;
      tx_byte   <= BYTE_IDLE;
      blk_addr  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_index <= '0;
    end else begin
      mem_we    <= 1'b0;
      cmd_valid <= 1'b0;
      if (!active) begin
        state   <= IDLE;
        cnt     <= '0;
        tx_byte <= BYTE_IDLE;
      end else if (rx_valid) begin
        tx_byte <= BYTE_IDLE;
        case (state)
          IDLE: if (rx_byte[7:6] == 2'b01) begin
            cur_index <= rx_byte[5:0];
            cnt       <= '0;
            state     <= CMD_RX;
          end
          CMD_RX: if (cnt != 9'd4) begin
            arg <= {arg[23:0], rx_byte};
            cnt <= cnt + 9'd1;
          end else begin
            cmd_valid <= 1'b1;
            cmd_index <= cur_index;
            app_cmd   <= (cur_index == CMD_APP);
            r1_resp   <= r1_for(cur_index, app_cmd, in_idle);
            rd_go     <= (cur_index == CMD_READ_SINGLE) && !in_idle;
            wr_go     <= (cur_index == CMD_WRITE_SINGLE) && !in_idle;
            if ((cur_index == CMD_READ_SINGLE || cur_index == CMD_WRITE_SINGLE) && !in_idle)
              blk_addr <= arg;
            if (cur_index == CMD_GO_IDLE)
              in_idle <= 1'b1;
            else if (cur_index == CMD_SD_SEND_OP && app_cmd)
              in_idle <= 1'b0;
            state <= NCR;
          end
          NCR: begin
            tx_byte <= r1_resp;
            state   <= R1;
          end
          R1: if (rd_go) begin
            mem_addr <= '0;
            state    <= RD_GAP;
          end else if (wr_go) begin
            state <= WR_WAIT;
          end else begin
            state <= IDLE;
          end
          RD_GAP: begin
            tx_byte <= TOKEN_START;
            state   <= RD_TOKEN;
          end
          RD_TOKEN: begin
            tx_byte <= mem_rdata;
            cnt     <= '0;
            state   <= RD_DATA;
          end
          RD_DATA: if (cnt == ADDR_LAST) begin
            cnt   <= '0;
            state <= RD_CRC;
          end else begin
            tx_byte <= mem_rdata;
            cnt     <= cnt + 9'd1;
          end
          RD_CRC: if (cnt == '0) cnt <= 9'd1;
                  else state <= IDLE;
          WR_WAIT: if (rx_byte == TOKEN_START) begin
            cnt   <= '0;
            state <= WR_DATA;
          end
          WR_DATA: begin
            mem_we    <= 1'b1;
            mem_wdata <= rx_byte;
            mem_addr  <= cnt;
            if (cnt == ADDR_LAST) begin
              cnt   <= '0;
              state <= WR_CRC;
            end else begin
              cnt <= cnt + 9'd1;
            end
          end
          WR_CRC: if (cnt == '0) begin
            cnt <= 9'd1;
          end else begin
            tx_byte <= TOKEN_DATA_ACCEPT;
            state   <= WR_RESP;
          end
          WR_RESP: if (BUSY_BYTES == 0) begin
            state <= IDLE;
          end else begin
            tx_byte <= '0;
            cnt     <= '0;
            state   <= WR_BUSY;
          end
          WR_BUSY: if (cnt == BUSY_LAST) begin
            state <= IDLE;
          end else begin
            tx_byte <= '0;
            cnt     <= cnt + 9'd1;
          end
          default: state <= IDLE;
        endcase
      end else if (tx_load && state == RD_DATA && mem_addr != ADDR_LAST) begin
        // Advance the read address as soon as a data byte is taken, a full byte ahead.
        mem_addr <= mem_addr + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: a mode-0 SPI initiator drives directed commands,
// scoreboard queues hold the expected miso bytes, writes and command decodes.
module tb_sd_spi_responder;

  logic        clk = 1'b0;
  logic        rst, cs, sclk, mosi, miso;
  logic [31:0] blk_addr;
  logic [8:0]  mem_addr;
  logic [7:0]  mem_rdata, mem_wdata;
  logic        mem_we, cmd_valid;
  logic [5:0]  cmd_index;

  int checks   = 0;
  int failures = 0;
  int half     = 4;
  int wr_seen  = 0;

  logic [7:0]  q_miso[$];
  logic [16:0] q_wr[$];
  logic [5:0]  q_cmd[$];
  logic [7:0]  got;
  event        byte_done;

  always #5 clk = ~clk;

  sd_spi_responder #(.BUSY_BYTES(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .blk_addr  (blk_addr),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .cmd_valid (cmd_valid),
    .cmd_index (cmd_index)
  );

  function automatic logic [7:0] rd_model(input logic [8:0] a);
    return a[7:0] ^ 8'hA5 ^ {a[8], 7'd0};
  endfunction

  always @(posedge clk) mem_rdata <= rd_model(mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp);
    logic [7:0] sh;
    sh = '0;
    q_miso.push_back(exp);
    for (int b = 7; b >= 0; b--) begin
      mosi = tx[b];
      repeat (half) @(negedge clk);
      sh = {sh[6:0], miso};
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
    got = sh;
    ->byte_done;
  endtask

  task automatic cmd(input logic [5:0] idx, input logic [31:0] a, input logic [7:0] r1);
    q_cmd.push_back(idx);
    xfer({2'b01, idx}, 8'hFF);
    xfer(a[31:24], 8'hFF);
    xfer(a[23:16], 8'hFF);
    xfer(a[15:8], 8'hFF);
    xfer(a[7:0], 8'hFF);
    xfer(8'h95, 8'hFF);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, r1);
  endtask

  initial begin : miso_monitor
    logic [7:0] e;
    forever begin
      @(byte_done);
      checks++;
      if (q_miso.size() == 0) begin
        failures++;
        $display("FAIL miso_byte: got %0h expected none", got);
      end else begin
        e = q_miso.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL miso_byte: got %0h expected %0h", got, e);
        end
      end
    end
  end

  always @(negedge clk) begin : wr_monitor
    logic [16:0] e;
    if (mem_we === 1'b1) begin
      checks++;
      wr_seen++;
      if (q_wr.size() == 0) begin
        failures++;
        $display("FAIL mem_write: got addr %0d data %0h expected none", mem_addr, mem_wdata);
      end else begin
        e = q_wr.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          failures++;
          $display("FAIL mem_write: got addr %0d data %0h expected addr %0d data %0h",
                   mem_addr, mem_wdata, e[16:8], e[7:0]);
        end
      end
    end
  end

  always @(negedge clk) begin : cmd_monitor
    logic [5:0] e;
    if (cmd_valid === 1'b1) begin
      checks++;
      if (q_cmd.size() == 0) begin
        failures++;
        $display("FAIL cmd_valid: got index %0d expected none", cmd_index);
      end else begin
        e = q_cmd.pop_front();
        if (cmd_index !== e) begin
          failures++;
          $display("FAIL cmd_index: got %0d expected %0d", cmd_index, e);
        end
      end
    end
  end

  initial begin : watchdog
    #950000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_miso", 32'(miso), 32'h1);
    check("rst_blk_addr", blk_addr, 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'h0);
    check("rst_cmd_index", 32'(cmd_index), 32'h0);

    cs = 1'b0;
    repeat (8) @(negedge clk);
    cmd(6'd0, 32'h0, 8'h01);
    cmd(6'd9, 32'h0, 8'h05);
    cmd(6'd41, 32'h0, 8'h05);
    cmd(6'd55, 32'h0, 8'h01);
    cmd(6'd41, 32'h0, 8'h00);
    cmd(6'd9, 32'h0, 8'h04);

    // Single-block read; host sends command-like bytes during data to show they are ignored.
    cmd(6'd17, 32'h0000_0010, 8'h00);
    check("rd_blk_addr", blk_addr, 32'h10);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'hFE);
    for (int i = 0; i < 512; i++) xfer(8'h40 | 8'(i & 1), rd_model(9'(i)));
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'hFF);
    check("rd_mem_addr_saturated", 32'(mem_addr), 32'd511);

    cmd(6'd24, 32'h0000_0020, 8'h00);
    check("wr_blk_addr", blk_addr, 32'h20);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFE, 8'hFF);
    for (int i = 0; i < 512; i++) begin
      q_wr.push_back({9'(i), 8'(i)});
      xfer(8'(i), 8'hFF);
    end
    xfer(8'hAA, 8'hFF);
    xfer(8'hBB, 8'hFF);
    xfer(8'hFF, 8'h05);
    for (int i = 0; i < 4; i++) xfer(8'hFF, 8'h00);
    xfer(8'hFF, 8'hFF);
    check("wr_count_full", 32'(wr_seen), 32'd512);

    half = 8;
    cmd(6'd9, 32'h0, 8'h04);
    cmd(6'd16, 32'h0000_0200, 8'h00);
    half = 4;

    cmd(6'd0, 32'h0, 8'h01);
    cmd(6'd17, 32'h0000_0040, 8'h05);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'hFF);
    check("rejected_blk_addr", blk_addr, 32'h20);

    cmd(6'd55, 32'h0, 8'h01);
    cmd(6'd41, 32'h0, 8'h00);
    cmd(6'd24, 32'h0000_0050, 8'h00);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFE, 8'hFF);
    for (int i = 0; i < 100; i++) begin
      q_wr.push_back({9'(i), 8'(i) ^ 8'h3C});
      xfer(8'(i) ^ 8'h3C, 8'hFF);
    end
    cs = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_miso", 32'(miso), 32'h1);
    repeat (20) @(negedge clk);
    check("wr_count_abort", 32'(wr_seen), 32'd612);

    cs = 1'b0;
    repeat (8) @(negedge clk);
    cmd(6'd0, 32'h0, 8'h01);
    repeat (8) @(negedge clk);

    check("miso_queue_drained", 32'(q_miso.size()), 32'd0);
    check("cmd_queue_drained", 32'(q_cmd.size()), 32'd0);
    check("wr_queue_drained", 32'(q_wr.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
